// File: rtl/sram_stream_pkg.sv
// sram_stream_pkg: FSM state type and output FIFO depth shared by the
// SRAM stream reader and its FIFO.
package sram_stream_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  localparam int FIFO_DEPTH = 2;
endpackage

// File: rtl/sync_fifo2.sv
// sync_fifo2: two-entry synchronous FIFO with a combinational head read and
// simultaneous push/pop that leaves the occupancy unchanged.
module sync_fifo2
  import sram_stream_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty
);
  logic [width-1:0] mem_q [FIFO_DEPTH];
  logic [width-1:0] mem_d [FIFO_DEPTH];
  logic wp_q, wp_d, rp_q, rp_d;
  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wp_q] = din;
    wp_d  = wp_q ^ push;
    rp_d  = rp_q ^ pop;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = mem_q[rp_q];
  assign full  = cnt_q == 2'(FIFO_DEPTH);
  assign empty = cnt_q == 2'd0;
endmodule

// File: rtl/sram_stream_reader.sv
// sram_stream_reader: burst-reads COUNT words from a synchronous SRAM starting
// at BASE_ADDR and streams them out over a valid/ready interface.
module sram_stream_reader
  import sram_stream_pkg::*;
#(
  parameter int address_width = 22,
  parameter int data_width    = 2,
  localparam int W = (1 << data_width) * 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     START,
  input  logic [address_width-1:0] BASE_ADDR,
  input  logic [address_width:0]   COUNT,
  output logic                     BUSY,
  output logic                     DONE,
  output logic [address_width-1:0] MEM_READ_ADDR,
  output logic                     MEM_OE,
  input  logic [W-1:0]             MEM_DATA,
  output logic [W-1:0]             STREAM_DATA,
  output logic                     STREAM_VALID,
  input  logic                     STREAM_READY
);
  state_t state_q, state_d;
  logic [address_width-1:0] addr_q, addr_d;
  logic [address_width:0] rem_q, rem_d, out_q, out_d;
  logic oe_q, oe_d, p_q, done_q, done_d, sv_q, sv_d;
  logic [W-1:0] sd_q, sd_d;
  logic hs, take, f_push, f_pop, f_full, f_empty, credit;
  logic [W-1:0] f_dout;
  logic [2:0] used;

  sync_fifo2 #(.width(W)) u_fifo (
    .clk  (CLK),
    .rst  (RST),
    .push (f_push),
    .pop  (f_pop),
    .din  (MEM_DATA),
    .dout (f_dout),
    .full (f_full),
    .empty(f_empty)
  );

  // The output register sits in front of the FIFO head; returning data
  // bypasses the FIFO whenever it is empty and the register is free.
  always_comb begin
    hs     = sv_q && STREAM_READY;
    take   = !sv_q || hs;
    f_pop  = take && !f_empty;
    f_push = p_q && !(take && f_empty);
    sv_d   = take ? (!f_empty || p_q) : 1'b1;
    sd_d   = !take ? sd_q : !f_empty ? f_dout : p_q ? MEM_DATA : sd_q;
    used   = (f_full ? 3'd2 : {2'b0, !f_empty}) + {2'b0, sv_q} + {2'b0, p_q} + {2'b0, oe_q};
    credit = used < 3'(FIFO_DEPTH + 1) + {2'b0, hs};
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    out_d   = hs ? out_q - 1 : out_q;
    oe_d    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (START) begin
        done_d  = COUNT == 0;
        oe_d    = COUNT != 0;
        state_d = COUNT != 0 ? READ : IDLE;
        addr_d  = COUNT != 0 ? BASE_ADDR : addr_q;
        rem_d   = COUNT != 0 ? COUNT - 1 : rem_q;
        out_d   = COUNT;
      end
      READ: begin
        oe_d    = rem_q != 0 && credit;
        addr_d  = oe_d ? addr_q + 1 : addr_q;
        rem_d   = oe_d ? rem_q - 1 : rem_q;
        state_d = rem_q == 0 ? DRAIN : READ;
      end
      DRAIN: if (hs && out_q == 1) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      out_q   <= '0;
      oe_q    <= 1'b0;
      p_q     <= 1'b0;
      done_q  <= 1'b0;
      sv_q    <= 1'b0;
      sd_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      p_q     <= oe_q;
      done_q  <= done_d;
      sv_q    <= sv_d;
      sd_q    <= sd_d;
    end
  end

  assign BUSY          = state_q != IDLE;
  assign DONE          = done_q;
  assign MEM_READ_ADDR = addr_q;
  assign MEM_OE        = oe_q;
  assign STREAM_DATA   = sd_q;
  assign STREAM_VALID  = sv_q;
endmodule

// File: tb/tb_sram_stream_reader.sv
// tb_sram_stream_reader: directed bursts against SRAM models holding word[a]=a,
// with a scoreboard of expected read addresses and stream words.
module tb_sram_stream_reader;
  logic CLK = 1'b0, RST = 1'b1, START = 1'b0, STREAM_READY = 1'b0;
  logic [21:0] BASE_ADDR = '0;
  logic [22:0] COUNT = '0;
  logic BUSY, DONE, MEM_OE, STREAM_VALID;
  logic [21:0] MEM_READ_ADDR;
  logic [31:0] MEM_DATA = '0, STREAM_DATA;

  logic start_w = 1'b0;
  logic [3:0] base_w = '0, addr_w;
  logic [4:0] count_w = '0;
  logic busy_w, done_w, oe_w, valid_w;
  logic [31:0] mdata_w = '0, sdata_w;

  int tests = 0, failed = 0, cyc_n = 0;
  int hs_n, oe_n, done_n, wdone_n, first_hs, last_hs, done_cyc, k0;
  bit toggle = 1'b0;
  logic [31:0] exp_q[$];
  logic [21:0] addr_exp[$];
  logic [3:0] waddr[$];
  logic [31:0] wdata[$];
  logic [3:0] wexp [4] = '{4'hE, 4'hF, 4'h0, 4'h1};

  sram_stream_reader dut (
    .CLK(CLK), .RST(RST), .START(START), .BASE_ADDR(BASE_ADDR), .COUNT(COUNT),
    .BUSY(BUSY), .DONE(DONE), .MEM_READ_ADDR(MEM_READ_ADDR), .MEM_OE(MEM_OE),
    .MEM_DATA(MEM_DATA), .STREAM_DATA(STREAM_DATA), .STREAM_VALID(STREAM_VALID),
    .STREAM_READY(STREAM_READY)
  );

  sram_stream_reader #(.address_width(4)) dut_w (
    .CLK(CLK), .RST(RST), .START(start_w), .BASE_ADDR(base_w), .COUNT(count_w),
    .BUSY(busy_w), .DONE(done_w), .MEM_READ_ADDR(addr_w), .MEM_OE(oe_w),
    .MEM_DATA(mdata_w), .STREAM_DATA(sdata_w), .STREAM_VALID(valid_w),
    .STREAM_READY(1'b1)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (MEM_OE) MEM_DATA <= 32'(MEM_READ_ADDR);
    if (oe_w) mdata_w <= 32'(addr_w);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    hs_n = 0; oe_n = 0; done_n = 0; wdone_n = 0;
    first_hs = -1; last_hs = -1; done_cyc = -1;
  endtask

  // Scoreboard the cycle about to close, then advance one clock.
  task automatic cyc();
    logic stall;
    logic [31:0] held, e;
    logic [21:0] a;
    if (STREAM_VALID && STREAM_READY) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      chk("stream_data", STREAM_DATA, e);
      hs_n++;
      if (hs_n == 1) first_hs = cyc_n;
      last_hs = cyc_n;
    end
    if (MEM_OE) begin
      a = (addr_exp.size() > 0) ? addr_exp.pop_front() : 'x;
      chk("read_addr", MEM_READ_ADDR, a);
      oe_n++;
    end
    if (DONE) begin
      done_n++;
      done_cyc = cyc_n;
      chk("busy_in_done", BUSY, 0);
    end
    if (oe_w) waddr.push_back(addr_w);
    if (valid_w) wdata.push_back(sdata_w);
    if (done_w) wdone_n++;
    stall = STREAM_VALID && !STREAM_READY;
    held = STREAM_DATA;
    @(posedge CLK);
    #1;
    cyc_n++;
    if (stall) begin
      chk("stall_valid", STREAM_VALID, 1);
      chk("stall_data", STREAM_DATA, held);
    end
    if (toggle) STREAM_READY = !STREAM_READY;
  endtask

  task automatic burst(input logic [21:0] b, input logic [22:0] n);
    for (int i = 0; i < int'(n); i++) begin
      addr_exp.push_back(b + 22'(i));
      exp_q.push_back(32'(b + 22'(i)));
    end
    BASE_ADDR = b;
    COUNT = n;
    START = 1'b1;
    cyc();
    START = 1'b0;
    k0 = cyc_n;
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while (!DONE && n < budget) begin
      cyc();
      n++;
    end
    chk("done_seen", DONE, 1);
    cyc();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_done"}, DONE, 0);
    chk({tag, "_oe"}, MEM_OE, 0);
    chk({tag, "_valid"}, STREAM_VALID, 0);
    chk({tag, "_addr"}, MEM_READ_ADDR, 0);
    chk({tag, "_data"}, STREAM_DATA, 0);
  endtask

  initial begin
    clear_stats();
    repeat (3) cyc();
    check_idle_outputs("reset");

    // Single burst straight out of reset, READY held high
    RST = 1'b0;
    STREAM_READY = 1'b1;
    clear_stats();
    burst(22'h10, 4);
    chk("t1_oe_e1", MEM_OE, 1);
    chk("t1_busy_e1", BUSY, 1);
    run_until_done(20);
    chk("t1_first_word_cycle", first_hs, k0 + 2);
    chk("t1_last_word_cycle", last_hs, k0 + 5);
    chk("t1_words", hs_n, 4);
    chk("t1_done_cycle", done_cyc, k0 + 6);
    chk("t1_done_pulses", done_n, 1);
    chk("t1_done_width", DONE, 0);
    chk("t1_leftover", exp_q.size(), 0);

    // Backpressure: READY toggles every cycle
    clear_stats();
    toggle = 1'b1;
    burst(22'h100, 8);
    run_until_done(100);
    toggle = 1'b0;
    STREAM_READY = 1'b1;
    chk("t2_words", hs_n, 8);
    chk("t2_reads", oe_n, 8);
    chk("t2_done_pulses", done_n, 1);
    chk("t2_leftover", exp_q.size(), 0);

    // Address wrap on the 4-bit instance
    clear_stats();
    waddr.delete();
    wdata.delete();
    base_w = 4'hE;
    count_w = 5'd4;
    start_w = 1'b1;
    cyc();
    start_w = 1'b0;
    repeat (10) cyc();
    chk("t3_reads", waddr.size(), 4);
    chk("t3_words", wdata.size(), 4);
    chk("t3_done_pulses", wdone_n, 1);
    for (int i = 0; i < 4; i++) begin
      if (i < waddr.size()) chk("t3_addr", waddr[i], wexp[i]);
      if (i < wdata.size()) chk("t3_data", wdata[i], 32'(wexp[i]));
    end

    // Zero count: DONE next cycle, no reads, BUSY low
    clear_stats();
    burst(22'h20, 0);
    chk("t4_done_e1", DONE, 1);
    chk("t4_busy_e1", BUSY, 0);
    chk("t4_oe_e1", MEM_OE, 0);
    cyc();
    chk("t4_done_width", DONE, 0);
    repeat (3) cyc();
    chk("t4_reads", oe_n, 0);
    chk("t4_done_pulses", done_n, 1);

    // Reset after 3 of 10 words, then a fresh burst
    clear_stats();
    burst(22'h200, 10);
    for (int n = 0; n < 50 && hs_n < 3; n++) cyc();
    chk("t5_words_before_reset", hs_n, 3);
    RST = 1'b1;
    #1;
    check_idle_outputs("t5_async");
    exp_q.delete();
    addr_exp.delete();
    clear_stats();
    #3;
    RST = 1'b0;
    repeat (5) cyc();
    chk("t5_no_done", done_n, 0);
    chk("t5_no_words", hs_n, 0);
    chk("t5_no_reads", oe_n, 0);
    burst(22'h40, 2);
    run_until_done(20);
    chk("t5_words", hs_n, 2);
    chk("t5_done_pulses", done_n, 1);
    chk("t5_leftover", exp_q.size(), 0);

    // START while busy is ignored
    clear_stats();
    burst(22'h300, 6);
    cyc();
    BASE_ADDR = 22'h500;
    COUNT = 23'd3;
    START = 1'b1;
    cyc();
    cyc();
    START = 1'b0;
    run_until_done(40);
    repeat (4) cyc();
    chk("t6_words", hs_n, 6);
    chk("t6_reads", oe_n, 6);
    chk("t6_done_pulses", done_n, 1);
    chk("t6_busy_after", BUSY, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
